flag_ctrl: RTL

Condition-flag controller for the pipelined CPU: owns the architectural NZCV register fed by the ALU flag outputs. It captures flags from flag-setting instructions (ADDS, SUBS, ANDS) in EX, holds them in a MEM-stage pending slot, and commits them one cycle later. It evaluates B.cond conditions in ID using the youngest valid flags, forwarding from EX or the pending slot. It raises a hazard stall when forwarding from EX is disabled.

---
 rtl/flag_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/flag_ctrl.sv
// flag_ctrl: condition-flag (NZCV) controller for the pipelined CPU.
//
// Captures ALU flags from flag-setting instructions in EX into a MEM-stage
// pending slot and commits them to the architectural NZCV register one
// edge later. B.cond conditions in ID are evaluated against the youngest
// valid flags: live EX flags (when FWD_EX=1), then the pending slot, then
// the committed register. With FWD_EX=0, a branch in ID behind a flag
// setter in EX raises hazard_stall_o instead of forwarding.
//
// Ports:
//   clk               system clock, rising edge
//   rst_n             asynchronous active-low reset
//   ex_valid_i        EX stage holds a real instruction
//   ex_set_flags_i    EX instruction writes flags
//   ex_zero_i, ex_negative_i, ex_carry_out_i, ex_overflow_i
//                     ALU flag outputs of the EX instruction
//   stall_i           pipeline freeze: no capture, no commit
//   flush_i           squash the EX instruction (its flags are never captured)
//   br_valid_i        ID holds a B.cond
//   br_cond_i[3:0]    ARM condition code of that B.cond
//   nzcv_o[3:0]       committed flags {N,Z,C,V}
//   cond_true_o       br_cond_i satisfied by the evaluation flags
//   hazard_stall_o    ID must stall one cycle (FWD_EX=0 only)
//   update_count_o    number of commits since reset, wraps modulo 2^CNT_W
module flag_ctrl #(
  parameter bit          FWD_EX = 1'b1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid_i,
  input  logic             ex_set_flags_i,
  input  logic             ex_zero_i,
  input  logic             ex_negative_i,
  input  logic             ex_carry_out_i,
  input  logic             ex_overflow_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             br_valid_i,
  input  logic [3:0]       br_cond_i,
  output logic [3:0]       nzcv_o,
  output logic             cond_true_o,
  output logic             hazard_stall_o,
  output logic [CNT_W-1:0] update_count_o
);

  logic             ex_fire;
  logic [3:0]       ex_nzcv;

  logic             pend_valid_q, pend_valid_d;
  logic [3:0]       pend_nzcv_q, pend_nzcv_d;
  logic [3:0]       nzcv_q, nzcv_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0]       evf;
  logic             f_n, f_z, f_c, f_v;

  assign ex_fire = ex_valid_i & ex_set_flags_i & ~flush_i;
  assign ex_nzcv = {ex_negative_i, ex_zero_i, ex_carry_out_i, ex_overflow_i};

  // Next-state for the pending slot and the committed register. The pending
  // slot is older than any flush source, so it commits unconditionally
  // whenever the pipeline is not frozen.
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_nzcv_d  = pend_nzcv_q;
    nzcv_d       = nzcv_q;
    cnt_d        = cnt_q;
    if (!stall_i) begin
      pend_valid_d = ex_fire;
      if (ex_fire) begin
        pend_nzcv_d = ex_nzcv;
      end
      if (pend_valid_q) begin
        nzcv_d = pend_nzcv_q;
        cnt_d  = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid_q <= 1'b0;
      pend_nzcv_q  <= 4'b0000;
      nzcv_q       <= 4'b0000;
      cnt_q        <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_nzcv_q  <= pend_nzcv_d;
      nzcv_q       <= nzcv_d;
      cnt_q        <= cnt_d;
    end
  end

  // Youngest valid flags win. With FWD_EX=0 the EX term is constant-false, so
  // ID only ever sees pending or committed flags and relies on hazard_stall_o.
  always_comb begin
    if (FWD_EX && ex_fire) begin
      evf = ex_nzcv;
    end else if (pend_valid_q) begin
      evf = pend_nzcv_q;
    end else begin
      evf = nzcv_q;
    end
  end

  assign {f_n, f_z, f_c, f_v} = evf;

  always_comb begin
    cond_true_o = 1'b1;
    unique case (br_cond_i)
      4'b0000: cond_true_o = f_z;
      4'b0001: cond_true_o = ~f_z;
      4'b0010: cond_true_o = f_c;
      4'b0011: cond_true_o = ~f_c;
      4'b0100: cond_true_o = f_n;
      4'b0101: cond_true_o = ~f_n;
      4'b0110: cond_true_o = f_v;
      4'b0111: cond_true_o = ~f_v;
      4'b1000: cond_true_o = f_c & ~f_z;
      4'b1001: cond_true_o = ~(f_c & ~f_z);
      4'b1010: cond_true_o = (f_n == f_v);
      4'b1011: cond_true_o = (f_n != f_v);
      4'b1100: cond_true_o = ~f_z & (f_n == f_v);
      4'b1101: cond_true_o = ~(~f_z & (f_n == f_v));
      4'b1110: cond_true_o = 1'b1;
      4'b1111: cond_true_o = 1'b1;
      default: cond_true_o = 1'b1;
    endcase
  end

  assign hazard_stall_o = !FWD_EX && br_valid_i && ex_fire;

  assign nzcv_o         = nzcv_q;
  assign update_count_o = cnt_q;

endmodule
